// File: rtl/timer_irq_periph.sv
// Memory-mapped reload timer with prescaler, sticky interrupt, LED register and free-running cycle counter.
// Reads are combinational (zero latency); writes land on the strobed clk edge; no backpressure, always ready.
module timer_irq_periph #(
  parameter logic [31:0] BASE     = 32'h4000_0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  led
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [31:0] A_TH      = BASE;
  localparam logic [31:0] A_TL      = BASE + 32'h04;
  localparam logic [31:0] A_TCON    = BASE + 32'h08;
  localparam logic [31:0] A_LED     = BASE + 32'h0C;
  localparam logic [31:0] A_SYSTICK = BASE + 32'h14;

  logic [31:0]   th;
  logic [31:0]   tl;
  logic          en;
  logic          ie;
  logic          st;
  logic [7:0]    led_q;
  logic [31:0]   systick;
  logic [PW-1:0] ps_cnt;

  logic sel_th, sel_tl, sel_tcon, sel_led, sel_systick;
  logic wr_th, wr_tl, wr_tcon, wr_led;
  logic tick, ovf;
  logic st_nxt;

  always_comb begin
    sel_th      = (addr == A_TH);
    sel_tl      = (addr == A_TL);
    sel_tcon    = (addr == A_TCON);
    sel_led     = (addr == A_LED);
    sel_systick = (addr == A_SYSTICK);
  end

  always_comb begin
    wr_th   = mem_wr & sel_th;
    wr_tl   = mem_wr & sel_tl;
    wr_tcon = mem_wr & sel_tcon;
    wr_led  = mem_wr & sel_led;
  end

  always_comb begin
    tick = en & (ps_cnt == PS_LAST);
    ovf  = tick & (tl == 32'hFFFF_FFFF);
  end

  // Software may only clear ST; a same-edge overflow set takes priority so no interrupt is lost.
  always_comb begin
    st_nxt = st;
    if (wr_tcon) begin
      st_nxt = st & wdata[2];
    end
    if (ovf && ie) begin
      st_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_cnt <= '0;
    end else if (!en || tick || (wr_tcon && !wdata[0])) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // A bus write to TL beats a same-edge increment or reload; reload uses the pre-write TH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tl <= '0;
    end else if (wr_tl) begin
      tl <= wdata;
    end else if (ovf) begin
      tl <= th;
    end else if (tick) begin
      tl <= tl + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= '0;
    end else if (wr_th) begin
      th <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en <= 1'b0;
      ie <= 1'b0;
      st <= 1'b0;
    end else begin
      st <= st_nxt;
      if (wr_tcon) begin
        en <= wdata[0];
        ie <= wdata[1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
    end else if (wr_led) begin
      led_q <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
    end
  end

  always_comb begin
    rdata = '0;
    if (mem_rd) begin
      if (sel_th) begin
        rdata = th;
      end else if (sel_tl) begin
        rdata = tl;
      end else if (sel_tcon) begin
        rdata = {29'd0, st, ie, en};
      end else if (sel_led) begin
        rdata = {24'd0, led_q};
      end else if (sel_systick) begin
        rdata = systick;
      end
    end
  end

  assign irq = ie & st;
  assign led = led_q;

endmodule

// File: tb/tb_timer_irq_periph.sv
// Directed bench for timer_irq_periph: one instance with PRESCALE=1, one with PRESCALE=4 on a shared bus.
module tb_timer_irq_periph;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED  = BASE + 32'h0C;
  localparam logic [31:0] A_GAP  = BASE + 32'h10;
  localparam logic [31:0] A_ST   = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [31:0] rdata, rdata4;
  logic        irq, irq4;
  logic [7:0]  led, led4;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] r1, r4, s0, s1;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
  } vec_t;
  vec_t tbl[10];

  timer_irq_periph #(.BASE(BASE), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .rdata(rdata), .irq(irq), .led(led)
  );

  timer_irq_periph #(.BASE(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .rdata(rdata4), .irq(irq4), .led(led4)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a;
    mem_rd = 1'b1;
    #1;
    r1 = rdata;
    r4 = rdata4;
    mem_rd = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    mem_wr = 1'b1;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{A_LED,  1'b1, 32'h0000_01A5, 32'h0000_00A5, 8'hA5};
    tbl[1] = '{A_TH,   1'b1, 32'h1234_5678, 32'h1234_5678, 8'hA5};
    tbl[2] = '{A_TL,   1'b1, 32'hCAFE_BABE, 32'hCAFE_BABE, 8'hA5};
    tbl[3] = '{A_TCON, 1'b1, 32'h0000_0006, 32'h0000_0002, 8'hA5};
    tbl[4] = '{A_TCON, 1'b1, 32'hFFFF_FFF8, 32'h0000_0000, 8'hA5};
    tbl[5] = '{A_GAP,  1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 8'hA5};
    tbl[6] = '{BASE + 32'h18, 1'b1, 32'h0000_0001, 32'h0000_0000, 8'hA5};
    tbl[7] = '{BASE + 32'h0D, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'hA5};
    tbl[8] = '{A_LED,  1'b1, 32'hFFFF_FF00, 32'h0000_0000, 8'h00};
    tbl[9] = '{A_LED,  1'b0, 32'h0000_0000, 32'h0000_0000, 8'h00};

    // Reset state
    #5;
    rd(A_TH);   chk("rst_th", r1, 32'h0);
    rd(A_TL);   chk("rst_tl", r1, 32'h0);
    rd(A_TCON); chk("rst_tcon", r1, 32'h0);
    rd(A_ST);   chk("rst_systick", r1, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1);

    // Register map table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) wr(tbl[i].a, tbl[i].wd);
      else step(1);
      rd(tbl[i].a);
      chk($sformatf("map_rd[%0d]", i), r1, tbl[i].exp_rd);
      chk($sformatf("map_led[%0d]", i), 32'(led), 32'(tbl[i].exp_led));
    end

    // SYSTICK delta and write-ignore
    rd(A_ST); s0 = r1;
    step(10);
    rd(A_ST); s1 = r1;
    chk("systick_delta10", s1 - s0, 32'd10);
    rd(A_ST); s0 = r1;
    wr(A_ST, 32'h0);
    rd(A_ST);
    chk("systick_wr_ignored", r1, s0 + 32'd1);

    // mem_rd gating and read-during-write
    wr(A_LED, 32'hA5);
    addr = A_LED;
    mem_rd = 1'b0;
    #1;
    chk("rdata_no_rd", rdata, 32'h0);
    @(negedge clk);
    addr = A_LED; wdata = 32'h33; mem_wr = 1'b1; mem_rd = 1'b1;
    #1;
    chk("rdwr_prewrite", rdata, 32'hA5);
    @(posedge clk);
    #1;
    chk("rdwr_led", 32'(led), 32'h33);
    chk("rdwr_after", rdata, 32'h33);
    mem_wr = 1'b0; mem_rd = 1'b0;

    // Reload and irq, PRESCALE=1
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    rd(A_TL); chk("rl_tl0", r1, 32'hFFFF_FFFE);
    step(1);
    rd(A_TL); chk("rl_tl1", r1, 32'hFFFF_FFFF);
    chk("rl_irq1", 32'(irq), 32'h0);
    step(1);
    rd(A_TL); chk("rl_reload", r1, 32'hFFFF_FFFC);
    chk("rl_irq_set", 32'(irq), 32'h1);
    wr(A_TCON, 32'h3);
    chk("per_clr_irq", 32'(irq), 32'h0);
    rd(A_TL); chk("per_tl", r1, 32'hFFFF_FFFD);
    step(1); chk("per_irq_c2", 32'(irq), 32'h0);
    step(1); chk("per_irq_c3", 32'(irq), 32'h0);
    step(1); chk("per_irq_c4", 32'(irq), 32'h1);
    rd(A_TL); chk("per_reload", r1, 32'hFFFF_FFFC);

    // Clear racing overflow on the same edge
    step(3);
    wr(A_TCON, 32'h3);
    chk("race_irq_kept", 32'(irq), 32'h1);
    rd(A_TCON); chk("race_tcon", r1, 32'h7);
    wr(A_TCON, 32'h3);
    chk("race_clear_later", 32'(irq), 32'h0);

    // IE masking
    wr(A_TCON, 32'h1);
    rd(A_TL); chk("mask_tl", r1, 32'hFFFF_FFFE);
    step(2);
    rd(A_TL); chk("mask_reload", r1, 32'hFFFF_FFFC);
    chk("mask_irq", 32'(irq), 32'h0);
    rd(A_TCON); chk("mask_st0", r1, 32'h1);
    wr(A_TCON, 32'h3);
    chk("mask_ie_on", 32'(irq), 32'h0);
    step(1); chk("mask_wait1", 32'(irq), 32'h0);
    step(1); chk("mask_wait2", 32'(irq), 32'h0);
    step(1); chk("mask_next_ovf", 32'(irq), 32'h1);
    wr(A_TCON, 32'h0);
    rd(A_TL); chk("dis_tick_completes", r1, 32'hFFFF_FFFD);
    chk("dis_irq", 32'(irq), 32'h0);
    step(3);
    rd(A_TL); chk("dis_frozen", r1, 32'hFFFF_FFFD);

    // TL write during tick, TH write during overflow
    wr(A_TCON, 32'h1);
    wr(A_TL, 32'h55);
    rd(A_TL); chk("tlwr_wins", r1, 32'h55);
    step(1);
    rd(A_TL); chk("tlwr_next", r1, 32'h56);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h20);
    rd(A_TL); chk("thwr_old_reload", r1, 32'hFFFF_FFFC);
    rd(A_TH); chk("thwr_new_th", r1, 32'h20);
    wr(A_TCON, 32'h0);

    // Prescaler, PRESCALE=4 instance
    wr(A_TL, 32'h0);
    wr(A_TCON, 32'h1);
    step(3);
    rd(A_TL); chk("ps_tl_c3", r4, 32'd0);
    step(1);
    rd(A_TL); chk("ps_tl_c4", r4, 32'd1);
    step(16);
    rd(A_TL); chk("ps_tl_c20", r4, 32'd5);
    wr(A_TCON, 32'h0);
    rd(A_TL); chk("ps_stop", r4, 32'd5);
    step(8);
    rd(A_TL); chk("ps_frozen", r4, 32'd5);

    // Reset asserted mid-count with irq high
    wr(A_TH, 32'h10);
    wr(A_LED, 32'h5A);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    step(1);
    chk("mid_irq_pre", 32'(irq), 32'h1);
    rd(A_TL); chk("mid_tl_pre", r1, 32'h10);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_irq", 32'(irq), 32'h0);
    chk("mid_led", 32'(led), 32'h0);
    rd(A_TL);   chk("mid_tl", r1, 32'h0);
    rd(A_TCON); chk("mid_tcon", r1, 32'h0);
    rd(A_ST);   chk("mid_systick", r1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/timer_irq_periph.md
Name: timer_irq_periph

Overview:
- Memory-mapped timer peripheral and interrupt source on the data bus.
- Drives the `irq` input of the CPU control unit.
- Reload-counter timer with prescaler, interrupt enable, and sticky pending status cleared by software.
- Also provides an LED output register and a free-running cycle counter.

Parameters:
- BASE, 32'h4000_0000, base byte address of the register block.
- PRESCALE, 1, number of clk cycles per timer tick (1 means tick every cycle; must be ≥1).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  32  byte address from ALU result
- wdata  in  32  store data
- mem_wr  in  1  write strobe, one cycle per store
- mem_rd  in  1  read strobe
- rdata  out  32  read data (combinational)
- irq  out  1  interrupt request to CPU control unit
- led  out  8  LED register output

Behaviour:
- Register map (full 32-bit match; unmapped addresses read 0, writes ignored):
  - BASE+0x00 TH, reload value.
  - BASE+0x04 TL, counter.
  - BASE+0x08 TCON. Bit0 = EN, bit1 = IE, bit2 = ST (pending). Bits 31:3 read 0.
  - BASE+0x0C LED. Bits 7:0 R/W; upper bits read 0.
  - BASE+0x14 SYSTICK. Read-only; writes ignored.
- Reset (reset=0, asynchronous): TH, TL, TCON, LED, SYSTICK, prescale counter all 0. irq=0, led=0.
- rdata = selected register when mem_rd=1 and address is mapped; 0 otherwise. Zero-cycle latency.
- Writes take effect at the clk edge where mem_wr=1.
- SYSTICK increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- Prescaler:
  - While EN=1, it counts 0..PRESCALE-1.
  - A tick is generated in the cycle the count equals PRESCALE-1; the count then returns to 0.
  - While EN=0, the prescale counter holds at 0 and no ticks occur.
- On tick with TL ≠ 0xFFFF_FFFF: TL ← TL+1.
- On tick with TL = 0xFFFF_FFFF (overflow):
  - TL ← TH.
  - If IE=1, ST ← 1. If IE=0, ST is unchanged.
- irq = IE & ST, combinational from registers. Held high until software clears ST or IE.
- TCON write: EN ← wdata[0], IE ← wdata[1], ST ← ST & wdata[2] (software can clear ST, never set it).
- Simultaneous events, same edge:
  - Overflow sets ST and software clears ST: ST=1. No interrupt is lost.
  - Write to TL during a tick: the written value wins; no increment or reload.
  - Write to TH during overflow: reload uses the old TH; TH takes the new value.
  - Write to TCON with EN=0 during a tick: that tick still completes; the prescaler resets to 0 next cycle.
- Reset asserted mid-count: all state clears immediately, without waiting for clk; irq drops asynchronously.
- mem_rd and mem_wr both high: the write occurs and rdata shows the pre-write value.

Test Plan:
- Reset: assert reset=0 mid-count with TL=0x10 → TL, TCON, SYSTICK, led read 0, irq=0 immediately.
- Reload and irq:
  - Stimulus: PRESCALE=1, write TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3.
  - Ticks 1–2: TL=0xFFFF_FFFF, then reload to 0xFFFF_FFFC; ST=1 and irq=1 in the cycle after the reload edge.
  - Period: irq re-asserts every 4 cycles after each clear.
- Clear race: with ST=1, write TCON=3 on the exact overflow edge → ST stays 1, irq stays 1. A write of TCON=3 one cycle later → irq=0.
- IE masking: TCON=1, force overflow → ST=0, irq=0. Then write TCON=3 → irq remains 0 until the next overflow.
- Prescaler: PRESCALE=4, TL=0, TCON=1 → TL reads 1 after 4 cycles and 5 after 20 cycles. Writing TCON=0 freezes TL.
- Bus map:
  - Write LED=0x1A5 → led=0xA5, LED readback 0x0000_00A5.
  - Write SYSTICK → ignored.
  - Read BASE+0x10 → 0.
  - mem_rd=0 → rdata=0.
  - SYSTICK readings 10 cycles apart differ by 10.
